// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hit path, whole-line fill in word order.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_dm #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instradr,
    input  logic        instrreq,
    output logic [31:0] instr,
    output logic        hit,
    input  logic        abort,
    input  logic        flush,
    output logic [31:0] mem_adr,
    output logic        mem_req,
    input  logic [31:0] mem_data,
    input  logic        mem_val
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hitcnt,
    output logic [31:0] misscnt
`endif
);
    localparam int IDX  = $clog2(LINES);
    localparam int OFF  = $clog2(WORDS);
    localparam int TAGW = 32 - 2 - OFF - IDX;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state, state_nx;
    logic [LINES-1:0]  valid;
    logic [TAGW-1:0]   tags [LINES];
    logic [31:0]       data [LINES][WORDS];
    logic [TAGW-1:0]   ftag;
    logic [IDX-1:0]    fidx;
    logic [OFF-1:0]    wcnt;
    logic              start, done, cancel;

    logic [TAGW-1:0]   a_tag;
    logic [IDX-1:0]    a_idx;
    logic [OFF-1:0]    a_off;
    logic              unused_bits;

    assign a_tag       = instradr[31:2+OFF+IDX];
    assign a_idx       = instradr[2+OFF+IDX-1:2+OFF];
    assign a_off       = instradr[2+OFF-1:2];
    assign unused_bits = ^instradr[1:0];

    assign instr   = data[a_idx][a_off];
    assign mem_req = reset && (state == FILL);
    assign mem_adr = mem_req ? {ftag, fidx, wcnt, 2'b00} : 32'd0;
    // flush kills a fill exactly like abort does
    assign cancel  = abort || flush;

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        done     = 1'b0;
        hit      = reset && instrreq && (state == IDLE) &&
                   valid[a_idx] && (tags[a_idx] == a_tag);
        unique case (state)
            IDLE: begin
                if (instrreq && !hit && !cancel) begin
                    start    = 1'b1;
                    state_nx = FILL;
                end
            end
            FILL: begin
                if (cancel) begin
                    state_nx = IDLE;
                end else if (mem_val && (wcnt == OFF'(WORDS - 1))) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            valid <= '0;
            wcnt  <= '0;
            ftag  <= '0;
            fidx  <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                ftag         <= a_tag;
                fidx         <= a_idx;
                wcnt         <= '0;
                valid[a_idx] <= 1'b0;
            end else if (state == FILL) begin
                if (cancel)
                    wcnt <= '0;
                else if (mem_val)
                    wcnt <= wcnt + 1'b1;   // last word wraps to 0 as FSM exits
            end
            if (done)
                valid[fidx] <= 1'b1;
            if (flush)
                valid <= '0;
        end
    end

    // Array storage carries no reset; a line is only usable once its valid bit is set.
    always_ff @(posedge clk) begin
        if (reset && (state == FILL) && mem_val && !cancel)
            data[fidx][wcnt] <= mem_data;
        if (done)
            tags[fidx] <= ftag;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            hitcnt  <= '0;
            misscnt <= '0;
        end else begin
            if (hit && (hitcnt != 32'hFFFF_FFFF))
                hitcnt <= hitcnt + 32'd1;
            if (start && (misscnt != 32'hFFFF_FFFF))
                misscnt <= misscnt + 32'd1;
        end
    end
`endif

endmodule
